uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one `uart_tx` serializer among `NUM_REQ` byte producers, such as the keypad encoder, the link relay and the status reporter.

- Each requester has a one-byte holding slot with a valid/ready handshake.
- The scheduler grants slots in rotating priority and drives the serializer's `i_Tx_DV`/`i_Tx_Byte`.
- It tracks the serializer's `o_Tx_Active`/`o_Tx_Done`.
- It returns a per-requester completion pulse.

It sits between the application logic and the single `uart_tx` instance on the board's TX pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx_sched.sv | 117 +++++++++++
 tb/tb_uart_tx_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX scheduler and related blocks.
package uart_pkg;

    localparam int BYTE_W      = 8;
    localparam int NUM_REQ_DEF = 4;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_LAUNCH     = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE       = ST_IDLE,
        LAUNCH     = ST_LAUNCH,
        WAIT_START = ST_WAIT_START,
        WAIT_DONE  = ST_WAIT_DONE
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i at or above ptr_i, wrapping.
// Zero latency; no handshake, found_o low when valid_i is empty.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Walk from farthest to nearest so the closest candidate to ptr_i wins.
        for (int k = N - 1; k >= 0; k--) begin
            int c;
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            if (valid_i[c]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin sharing of one uart_tx among NUM_REQ one-byte slots; DV 2 cycles after accept.
// A slot stays not-ready from accept until its LAUNCH cycle; launches wait for the serializer to be idle.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic [NUM_REQ-1:0]        i_Req_Valid,
    input  logic [BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]        o_Req_Ready,
    output logic [NUM_REQ-1:0]        o_Req_Done,
    output logic                      o_Tx_DV,
    output logic [BYTE_W-1:0]         o_Tx_Byte,
    input  logic                      i_Tx_Active,
    input  logic                      i_Tx_Done,
    output logic [IDX_W-1:0]          o_Grant_Idx,
    output logic                      o_Busy
);

    state_e                         state_q, state_d;
    logic [NUM_REQ-1:0]             slot_vld_q;
    logic [NUM_REQ-1:0][BYTE_W-1:0] slot_byte_q;
    logic [NUM_REQ-1:0]             slot_clr;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic [IDX_W-1:0]               grant_q, grant_d;
    logic [IDX_W-1:0]               pick_idx;
    logic                           pick_found;
    logic [BYTE_W-1:0]              tx_byte_q, tx_byte_d;
    logic                           tx_dv_q, tx_dv_d;
    logic [NUM_REQ-1:0]             done_q, done_d;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i (slot_vld_q),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        done_d    = '0;
        slot_clr  = '0;
        case (state_q)
            IDLE: begin
                // Done is held for two cycles; waiting it out keeps DV off the serializer's cleanup.
                if (pick_found && !i_Tx_Active && !i_Tx_Done) begin
                    grant_d   = pick_idx;
                    tx_byte_d = slot_byte_q[pick_idx];
                    tx_dv_d   = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                slot_clr[grant_q] = 1'b1;
                state_d           = WAIT_START;
            end
            WAIT_START: begin
                if (i_Tx_Active) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_Tx_Done) begin
                    done_d[grant_q] = 1'b1;
                    if (int'(grant_q) == NUM_REQ - 1) ptr_d = '0;
                    else                              ptr_d = grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            slot_vld_q  <= '0;
            slot_byte_q <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            tx_byte_q   <= '0;
            tx_dv_q     <= 1'b0;
            done_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            done_q    <= done_d;
            for (int n = 0; n < NUM_REQ; n++) begin
                if (slot_clr[n]) begin
                    slot_vld_q[n] <= 1'b0;
                end else if (i_Req_Valid[n] && !slot_vld_q[n]) begin
                    slot_vld_q[n]  <= 1'b1;
                    slot_byte_q[n] <= i_Req_Byte[BYTE_W*n +: BYTE_W];
                end
            end
        end
    end

    assign o_Req_Ready = ~slot_vld_q;
    assign o_Req_Done  = done_q;
    assign o_Tx_DV     = tx_dv_q;
    assign o_Tx_Byte   = tx_byte_q;
    assign o_Grant_Idx = grant_q;
    assign o_Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench: serializer model plus a slot/pointer reference model of the scheduler.
module tb_uart_tx_sched;

    localparam int N   = 4;
    localparam int CPB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_vld = '0;
    logic [8*N-1:0] req_byte = '0;
    logic [N-1:0]   o_ready, o_done;
    logic           tx_dv, busy;
    logic [7:0]     tx_byte;
    logic [1:0]     grant;
    logic           tx_active = 1'b0;
    logic           tx_done = 1'b0;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(N), .IDX_W(2)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_vld),
        .i_Req_Byte  (req_byte),
        .o_Req_Ready (o_ready),
        .o_Req_Done  (o_done),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Grant_Idx (grant),
        .o_Busy      (busy)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Serializer model: no reset, Done held two cycles like the board's uart_tx.
    int         s_st = 0, s_cnt = 0, s_bit = 0;
    logic [7:0] s_dat = '0;
    logic       ser_line = 1'b1;

    always @(posedge clk) begin
        case (s_st)
            0: begin
                ser_line <= 1'b1; tx_done <= 1'b0; s_cnt <= 0; s_bit <= 0;
                if (tx_dv) begin tx_active <= 1'b1; s_dat <= tx_byte; s_st <= 1; end
            end
            1: begin
                ser_line <= 1'b0;
                if (s_cnt < CPB - 1) s_cnt <= s_cnt + 1;
                else begin s_cnt <= 0; s_st <= 2; end
            end
            2: begin
                ser_line <= s_dat[s_bit];
                if (s_cnt < CPB - 1) s_cnt <= s_cnt + 1;
                else begin
                    s_cnt <= 0;
                    if (s_bit < 7) s_bit <= s_bit + 1;
                    else begin s_bit <= 0; s_st <= 3; end
                end
            end
            3: begin
                ser_line <= 1'b1;
                if (s_cnt < CPB - 1) s_cnt <= s_cnt + 1;
                else begin s_cnt <= 0; tx_done <= 1'b1; tx_active <= 1'b0; s_st <= 4; end
            end
            default: begin tx_done <= 1'b1; s_st <= 0; end
        endcase
    end

    // Reference model: which slots hold bytes, and where the rotation currently starts.
    logic       m_vld [N];
    logic [7:0] m_byte[N];
    int         m_ptr = 0;
    logic [N-1:0] acc1 = '0, acc2 = '0;
    logic [7:0] acc1_b[N], acc2_b[N];
    int         done_q[$];
    logic [7:0] ser_q[$];
    logic       rst_prev = 1'b1, dv_prev = 1'b0, done_p1 = 1'b0, done_p2 = 1'b0;
    logic [N-1:0] exp_rdy;
    int         w;
    logic       found;

    always @(negedge clk) begin
        if (rst_prev) begin
            for (int r = 0; r < N; r++) m_vld[r] = 1'b0;
            m_ptr = 0; acc1 = '0; acc2 = '0;
            done_q.delete();
        end else begin
            for (int r = 0; r < N; r++)
                if (acc2[r]) begin m_vld[r] = 1'b1; m_byte[r] = acc2_b[r]; end
        end
        for (int r = 0; r < N; r++) exp_rdy[r] = !(m_vld[r] || acc1[r]);
        chk("ready", 32'(o_ready), 32'(exp_rdy));
        if (tx_dv) begin
            chk("dv_guard", 32'({tx_active, tx_done}), 32'd0);
            chk("dv_width", 32'(dv_prev), 32'd0);
            found = 1'b0; w = 0;
            for (int k = 0; k < N; k++)
                if (!found && m_vld[(m_ptr + k) % N]) begin found = 1'b1; w = (m_ptr + k) % N; end
            chk("dv_found", 32'(found), 32'd1);
            if (found) begin
                chk("grant", 32'(grant), 32'(w));
                chk("tx_byte", 32'(tx_byte), 32'(m_byte[w]));
                m_vld[w] = 1'b0;
                m_ptr = (w + 1) % N;
                done_q.push_back(w);
                ser_q.push_back(m_byte[w]);
            end
        end
        if (o_done != '0) begin
            if (done_q.size() == 0) chk("done_unexpected", 32'(o_done), 32'd0);
            else begin
                w = done_q.pop_front();
                chk("done_idx", 32'(o_done), 32'(1) << w);
                chk("done_timing", 32'({done_p2, done_p1}), 32'd1);
            end
        end
        acc2 = acc1;
        for (int r = 0; r < N; r++) acc2_b[r] = acc1_b[r];
        acc1 = req_vld & o_ready & {N{!rst}};
        for (int r = 0; r < N; r++) acc1_b[r] = req_byte[8*r +: 8];
        done_p2 = done_p1; done_p1 = tx_done; dv_prev = tx_dv; rst_prev = rst;
    end

    // Line decoder samples each bit mid-cell and compares against the launched byte.
    logic       dec_busy = 1'b0;
    int         dec_cnt = 0;
    logic [9:0] frame = '0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (!dec_busy && ser_line == 1'b0) begin dec_busy = 1'b1; dec_cnt = 0; end
        if (dec_busy) begin
            if (dec_cnt % CPB == CPB / 2) begin
                frame[dec_cnt / CPB] = ser_line;
                if (dec_cnt / CPB == 9) begin
                    dec_busy = 1'b0;
                    if (ser_q.size() == 0) chk("serial_unexpected", 32'd1, 32'd0);
                    else begin
                        exp_b = ser_q.pop_front();
                        chk("serial_framing", 32'({frame[9], frame[0]}), 32'd2);
                        chk("serial_byte", 32'(frame[8:1]), 32'(exp_b));
                    end
                end
            end
            dec_cnt++;
        end
    end

    // Stimulus driver: 0 = drop valid once accepted, 1 = always offer fixed bytes, 2 = random.
    int           mode = 0;
    logic [7:0]   fixed_b[N];
    logic [N-1:0] acc_d;

    always begin
        @(negedge clk);
        acc_d = req_vld & o_ready & {N{!rst}};
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            case (mode)
                0: if (acc_d[r]) req_vld[r] = 1'b0;
                1: begin req_vld[r] = 1'b1; req_byte[8*r +: 8] = fixed_b[r]; end
                default: if (acc_d[r] || !req_vld[r]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_vld[r] = 1'b1; req_byte[8*r +: 8] = 8'($urandom);
                    end else req_vld[r] = 1'b0;
                end
            endcase
        end
    end

    task automatic offer(input int r, input logic [7:0] b);
        @(posedge clk); #1;
        req_vld[r] = 1'b1; req_byte[8*r +: 8] = b;
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while (i < budget && !(o_ready == '1 && !busy && !tx_active && !tx_done && req_vld == '0
                               && done_q.size() == 0 && ser_q.size() == 0 && !dec_busy)) begin
            @(negedge clk); i++;
        end
        chk("drain_in_budget", 32'(i < budget), 32'd1);
    endtask

    task automatic wait_bit(input int b);
        int i = 0;
        while (i < 2000 && !(s_st == 2 && s_bit == b)) begin @(negedge clk); i++; end
        chk("wait_data_bit", 32'(i < 2000), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'hF);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_dv", 32'(tx_dv), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        offer(2, 8'hA5);
        drain(500);

        // Pointer now sits at 3: requester 0 must win over 1 after the wrap.
        @(posedge clk); #1;
        req_vld[0] = 1'b1; req_byte[7:0] = 8'h5A;
        req_vld[1] = 1'b1; req_byte[15:8] = 8'hC3;
        drain(500);

        pulse_reset();
        for (int r = 0; r < N; r++) fixed_b[r] = 8'(8'h10 + r);
        mode = 1;
        repeat (600) @(posedge clk);
        mode = 0;
        drain(1000);

        offer(1, 8'h66);
        offer(3, 8'h99);
        wait_bit(0);
        @(negedge clk);
        if (o_ready[1]) offer(1, 8'h77);
        else            offer(3, 8'h88);
        wait_bit(4);
        pulse_reset();
        @(negedge clk);
        chk("mid_reset_ready", 32'(o_ready), 32'hF);
        offer(0, 8'h3C);
        drain(1000);

        mode = 2;
        repeat (3000) @(posedge clk);
        mode = 0;
        drain(2000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d/%0d", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

endmodule
